// File: rtl/f32_pkg.sv
// Shared float32 constants and field helpers for the recip/divide/multiply/int2float family.
package f32_pkg;

    localparam int          F32_BIAS    = 127;
    localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  F32_EXP_MAX = 8'hFF;

    function automatic logic f32_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f32_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] f32_mant(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/f32_classify.sv
// Operand classifier: zero (including flushed denormals), infinity and NaN.
module f32_classify
    import f32_pkg::*;
(
    input  logic [31:0] x,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    assign is_zero = (f32_exp(x) == 8'h00);
    assign is_inf  = (f32_exp(x) == F32_EXP_MAX) && (f32_mant(x) == 23'h0);
    assign is_nan  = (f32_exp(x) == F32_EXP_MAX) && (f32_mant(x) != 23'h0);

endmodule

// File: rtl/multiply_f32_seq.sv
// Fixed-latency float32 multiplier: one significand bit per cycle shift-add, then
// normalise/pack with truncation; results appear with a one-cycle rdy pulse.
module multiply_f32_seq
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        rdy,
    output logic [31:0] prod
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    localparam int MUL_STEPS = 24;

    state_t              state_q, state_d;
    logic                accept;
    logic [4:0]          cnt_q;
    logic                sign_q;
    logic signed [9:0]   exp_q;
    logic [47:0]         mcand_q;
    logic [23:0]         mplier_q;
    logic [47:0]         acc_q;
    logic                nan_q, inf_q, zero_q;
    logic [31:0]         res_q;

    logic                a_zero, a_inf, a_nan;
    logic                b_zero, b_inf, b_nan;
    logic signed [9:0]   exp_adj;
    logic [22:0]         mant_n;
    logic [31:0]         packed_res;

    f32_classify u_class_a (.x(a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
    f32_classify u_class_b (.x(b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

    // NOTE: every output of a combinational block gets a default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL:  if (cnt_q == 5'(MUL_STEPS - 1)) state_d = NORM;
            NORM: state_d = DONE;
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Product of two 1.x significands lies in [1,4); acc[47] flags the [2,4) half.
    always_comb begin
        exp_adj = exp_q + 10'(acc_q[47]);
        mant_n  = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
        if (nan_q)
            packed_res = F32_QNAN;
        else if (inf_q)
            packed_res = {sign_q, F32_EXP_MAX, 23'h0};
        else if (zero_q)
            packed_res = {sign_q, 31'h0};
        else if (exp_adj >= 10'sd255)
            packed_res = {sign_q, F32_EXP_MAX, 23'h0};
        else if (exp_adj <= 10'sd0)
            packed_res = {sign_q, 31'h0};
        else
            packed_res = {sign_q, exp_adj[7:0], mant_n};
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            rdy     <= 1'b0;
            prod    <= 32'h0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            rdy     <= (state_q == DONE);
            if (state_q == DONE)
                prod <= res_q;
            if (accept)
                busy <= 1'b1;
            else if (state_q == DONE)
                busy <= 1'b0;
            if (accept)
                cnt_q <= 5'd0;
            else if (state_q == MUL)
                cnt_q <= cnt_q + 5'd1;
        end
    end

    // NOTE: datapath registers carry no reset; each is loaded on accept before it
    // is ever read, so only the control registers above need one.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q   <= f32_sign(a) ^ f32_sign(b);
            exp_q    <= 10'(f32_exp(a)) + 10'(f32_exp(b)) - 10'(F32_BIAS);
            mcand_q  <= {24'h0, 1'b1, f32_mant(a)};
            mplier_q <= {1'b1, f32_mant(b)};
            acc_q    <= 48'h0;
            nan_q    <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            inf_q    <= a_inf | b_inf;
            zero_q   <= a_zero | b_zero;
        end else if (state_q == MUL) begin
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
        if (state_q == NORM)
            res_q <= packed_res;
    end

endmodule
